// File: rtl/ram_loader_if.sv
// ram_loader_if
//   Bundles the host/receive/RAM-write signals of ram_loader.
//   master modport: the host side that drives start/n_words and the byte stream
//                   and observes the RAM write port and status.
//   slave modport : the loader itself.
// Signals:
//   start, n_words          host request (n_words is AW+1 bits wide)
//   rx_valid, rx_data       byte stream in, rx_ready back-pressure out
//   ram_load, ram_address,  RAM write port
//   ram_in
//   busy, done,             transfer status
//   words_written, checksum
interface ram_loader_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);

  logic             start;
  logic [AW:0]      n_words;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic             ram_load;
  logic [AW-1:0]    ram_address;
  logic [WIDTH-1:0] ram_in;
  logic             busy;
  logic             done;
  logic [AW:0]      words_written;
  logic [WIDTH-1:0] checksum;

  modport master (
    output start, n_words, rx_valid, rx_data,
    input  rx_ready, ram_load, ram_address, ram_in,
    input  busy, done, words_written, checksum
  );

  modport slave (
    input  start, n_words, rx_valid, rx_data,
    output rx_ready, ram_load, ram_address, ram_in,
    output busy, done, words_written, checksum
  );
endinterface

// File: rtl/ram_loader.sv
// ram_loader
//   Assembles a byte-serial image (high byte first) into WIDTH-bit words and
//   writes them to the CPU data RAM at incrementing addresses starting from 0.
//   A transfer of min(n_words, DEPTH) words is started by a start pulse in IDLE;
//   done pulses for one cycle after the last word has been written.
// Parameters:
//   WIDTH  RAM word width, legal 9..16 (one word = two bytes, excess high bits dropped)
//   DEPTH  RAM depth in words; AW = $clog2(DEPTH)
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    ram_loader_if.slave: start/n_words, rx_valid/rx_data/rx_ready,
//          ram_load/ram_address/ram_in, busy/done/words_written/checksum
// Build option:
//   RAM_LOADER_CHECKSUM_EN  when defined, checksum is the running mod-2^WIDTH sum of
//                           the words written; otherwise checksum is tied to 0.
// All outputs come straight from registers.
module ram_loader #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  ram_loader_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_W   = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [AW:0]   ZERO_W  = {(AW+1){1'b0}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HI    = 3'd1;
  localparam logic [2:0] S_LO    = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  // Transfer length never exceeds the RAM, so the address cannot wrap.
  function automatic logic [AW:0] clamp_len(input logic [AW:0] n);
    if (n > DEPTH_C) begin
      return DEPTH_C;
    end else begin
      return n;
    end
  endfunction

  // High byte first; for WIDTH<16 the top bits of the high byte are dropped.
  function automatic logic [WIDTH-1:0] pack_word(input logic [7:0] hi, input logic [7:0] lo);
    logic [15:0] w;
    w = {hi, lo};
    return w[WIDTH-1:0];
  endfunction

  logic [2:0]       state_q,    state_d;
  logic [AW:0]      len_q,      len_d;
  logic [7:0]       hi_q,       hi_d;
  logic [AW-1:0]    addr_q,     addr_d;
  logic [WIDTH-1:0] ram_in_q,   ram_in_d;
  logic [AW:0]      ww_q,       ww_d;
  logic             rx_ready_q, rx_ready_d;
  logic             ram_load_q, ram_load_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
`ifdef RAM_LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] ck_q,       ck_d;
`endif

  logic        rx_fire_s;
  logic [AW:0] ww_inc_s;
  logic [AW:0] start_len_s;

  // A byte is consumed only when the registered ready meets a valid byte.
  assign rx_fire_s   = bus.rx_valid & rx_ready_q;
  assign ww_inc_s    = ww_q + ONE_W;
  assign start_len_s = clamp_len(bus.n_words);

  // Next-state and datapath logic of the loader FSM.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    hi_d     = hi_q;
    addr_d   = addr_q;
    ram_in_d = ram_in_q;
    ww_d     = ww_q;
`ifdef RAM_LOADER_CHECKSUM_EN
    ck_d     = ck_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          len_d  = start_len_s;
          addr_d = {AW{1'b0}};
          ww_d   = ZERO_W;
`ifdef RAM_LOADER_CHECKSUM_EN
          ck_d   = {WIDTH{1'b0}};
`endif
          if (start_len_s == ZERO_W) begin
            state_d = S_FIN;
          end else begin
            state_d = S_HI;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HI: begin
        if (rx_fire_s) begin
          hi_d    = bus.rx_data;
          state_d = S_LO;
        end else begin
          state_d = S_HI;
        end
      end
      S_LO: begin
        if (rx_fire_s) begin
          ram_in_d = pack_word(hi_q, bus.rx_data);
          state_d  = S_WRITE;
        end else begin
          state_d = S_LO;
        end
      end
      S_WRITE: begin
        ww_d = ww_inc_s;
`ifdef RAM_LOADER_CHECKSUM_EN
        ck_d = ck_q + ram_in_q;
`endif
        // On the last word the address stays on it so it remains visible after done.
        if (ww_inc_s == len_q) begin
          state_d = S_FIN;
        end else begin
          addr_d  = addr_q + ONE_A;
          state_d = S_HI;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status/strobe outputs are decoded from the next state so they can be registered.
  always_comb begin
    rx_ready_d = 1'b0;
    ram_load_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_d)
      S_HI: begin
        rx_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_LO: begin
        rx_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_WRITE: begin
        ram_load_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_FIN: begin
        done_d = 1'b1;
        busy_d = 1'b1;
      end
      default: begin
        rx_ready_d = 1'b0;
        ram_load_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset drops any partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= ZERO_W;
      hi_q       <= 8'h00;
      addr_q     <= {AW{1'b0}};
      ram_in_q   <= {WIDTH{1'b0}};
      ww_q       <= ZERO_W;
      rx_ready_q <= 1'b0;
      ram_load_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      hi_q       <= hi_d;
      addr_q     <= addr_d;
      ram_in_q   <= ram_in_d;
      ww_q       <= ww_d;
      rx_ready_q <= rx_ready_d;
      ram_load_q <= ram_load_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef RAM_LOADER_CHECKSUM_EN
  // Running checksum register, cleared on accepted start and by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ck_q <= {WIDTH{1'b0}};
    end else begin
      ck_q <= ck_d;
    end
  end

  assign bus.checksum = ck_q;
`else
  assign bus.checksum = {WIDTH{1'b0}};
`endif

  assign bus.rx_ready      = rx_ready_q;
  assign bus.ram_load      = ram_load_q;
  assign bus.ram_address   = addr_q;
  assign bus.ram_in        = ram_in_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.words_written = ww_q;
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader
//   Directed-plus-random bench for ram_loader. A behavioural RAM captures every
//   write; expected words, lengths, timing and checksums are computed from the
//   byte stream with plain arithmetic.
module tb_ram_loader;
  localparam int WIDTH = 16;
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_loader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  ram_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural RAM and write log, written only here.
  logic [WIDTH-1:0] ram_mem [DEPTH] = '{default: '0};
  int               wr_addr_log [4096];
  int               load_count = 0;

  always @(posedge clk) begin
    if (bus.ram_load === 1'b1) begin
      ram_mem[bus.ram_address]  <= bus.ram_in;
      wr_addr_log[load_count]   <= int'(bus.ram_address);
      load_count                <= load_count + 1;
    end
  end

  logic [WIDTH-1:0] exp_ram [DEPTH] = '{default: '0};
  logic [WIDTH-1:0] exp_last_in = '0;
  logic [7:0]       tx_bytes[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_random(input int nbytes);
    tx_bytes.delete();
    for (int i = 0; i < nbytes; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
  endtask

  // One transfer: n words, optional source stall after byte stall_at, optional
  // start pokes while busy, optional reset once abort_at bytes were consumed.
  task automatic do_load(input int n, input int stall_at, input int stall_len,
                         input bit poke, input int abort_at);
    int len, cyc, idx, stall_left, done_cyc, w0, exp_cyc, nw;
    bit saw_ready, stall_load, ok;
    logic [15:0]      w16;
    logic [WIDTH-1:0] words[$];
    logic [WIDTH-1:0] sum;
    len = (n > DEPTH) ? DEPTH : n;
    sum = '0;
    for (int k = 0; k < len; k++) begin
      w16 = {tx_bytes[2*k], tx_bytes[2*k+1]};
      words.push_back(w16[WIDTH-1:0]);
      sum = sum + w16[WIDTH-1:0];
    end
    w0 = load_count;
    bus.start   = 1'b1;
    bus.n_words = (AW+1)'(n);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1; idx = 0; stall_left = stall_len; saw_ready = 0; stall_load = 0; done_cyc = -1;
    chk("busy_after_start", 32'(bus.busy), 32'(1));
    while (cyc < 400) begin
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (abort_at >= 0 && idx == abort_at) break;
      saw_ready = saw_ready | (bus.rx_ready === 1'b1);
      bus.start = poke && (cyc == 4);
      if (poke && cyc == 4) bus.n_words = (AW+1)'($urandom_range(1, 63));
      if (idx == stall_at && stall_left > 0) begin
        bus.rx_valid = 1'b0;
        stall_left--;
        if (bus.ram_load === 1'b1) stall_load = 1;
      end else if (idx < 2*len) begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = tx_bytes[idx];
        if (bus.rx_ready === 1'b1) idx++;
      end else begin
        bus.rx_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.rx_valid = 1'b0;
    bus.start    = 1'b0;

    if (abort_at >= 0) begin
      nw = abort_at / 2;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < nw; k++) exp_ram[k] = words[k];
      exp_last_in = '0;
      chk("abort_writes", 32'(load_count - w0), 32'(nw));
      chk("abort_busy", 32'(bus.busy), 32'(0));
      chk("abort_addr", 32'(bus.ram_address), 32'(0));
      repeat (4) @(negedge clk);
      chk("abort_no_more_load", 32'(load_count - w0), 32'(nw));
      chk("abort_idle", 32'(bus.busy), 32'(0));
    end else begin
      exp_cyc = (len == 0) ? 1 : (3*len + 1 + ((stall_at < 2*len) ? stall_len : 0));
      if (done_cyc < 0) chk("done_timeout", 32'(0), 32'(1));
      else chk("done_cycle", 32'(done_cyc), 32'(exp_cyc));
      if (len > 0) exp_last_in = words[len-1];
      chk("words_written", 32'(bus.words_written), 32'(len));
      chk("last_address", 32'(bus.ram_address), 32'((len > 0) ? len - 1 : 0));
      chk("last_ram_in", 32'(bus.ram_in), 32'(exp_last_in));
`ifdef RAM_LOADER_CHECKSUM_EN
      chk("checksum", 32'(bus.checksum), 32'(sum));
`else
      chk("checksum", 32'(bus.checksum), 32'(0));
`endif
      chk("rx_ready_seen", 32'(saw_ready), 32'(len != 0));
      if (stall_len > 0) chk("no_load_in_stall", 32'(stall_load), 32'(0));
      @(negedge clk);
      chk("done_one_cycle", 32'(bus.done), 32'(0));
      chk("idle_after_done", 32'(bus.busy), 32'(0));
      chk("write_count", 32'(load_count - w0), 32'(len));
      ok = 1;
      for (int k = 0; k < len; k++) if (wr_addr_log[w0+k] != k) ok = 0;
      chk("address_sequence", 32'(ok), 32'(1));
      for (int k = 0; k < len; k++) exp_ram[k] = words[k];
    end
    ok = 1;
    for (int k = 0; k < DEPTH; k++) if (ram_mem[k] !== exp_ram[k]) ok = 0;
    chk("ram_image", 32'(ok), 32'(1));
  endtask

  initial begin
    // Reset held two cycles with start asserted alongside.
    reset        = 1'b1;
    bus.start    = 1'b1;
    bus.n_words  = (AW+1)'(3);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'(0));
    chk("rst_ram_load", 32'(bus.ram_load), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_address", 32'(bus.ram_address), 32'(0));
    chk("rst_ram_in", 32'(bus.ram_in), 32'(0));
    chk("rst_words", 32'(bus.words_written), 32'(0));
    chk("rst_checksum", 32'(bus.checksum), 32'(0));
    reset     = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("start_with_reset_ignored", 32'(bus.busy), 32'(0));

    // Basic load with the known byte sequence.
    tx_bytes = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
    do_load(3, 999, 0, 1'b0, -1);
    chk("basic_word0", 32'(ram_mem[0]), 32'h1234);
    chk("basic_word2", 32'(ram_mem[2]), 32'h0001);
`ifdef RAM_LOADER_CHECKSUM_EN
    chk("basic_checksum", 32'(bus.checksum), 32'hBE02);
`endif

    // Source stalls between high and low bytes.
    fill_random(8);
    do_load(4, 1, 5, 1'b0, -1);
    fill_random(8);
    do_load(4, 3, 3, 1'b0, -1);

    // Clamp to DEPTH with start pokes while busy.
    fill_random(80);
    do_load(40, 999, 0, 1'b1, -1);

    // Zero length.
    tx_bytes.delete();
    do_load(0, 999, 0, 1'b0, -1);

    // Reset after the high byte of word 2, then a fresh transfer.
    fill_random(8);
    do_load(4, 999, 0, 1'b0, 5);
    fill_random(6);
    do_load(3, 999, 0, 1'b0, -1);

    // A few random lengths.
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, 12);
      fill_random(2*n);
      do_load(n, 999, 0, 1'b0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
